// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: controller state encoding, timing defaults
// and small elaboration helpers used by the control block, datapath and benches.
package stopwatch_pkg;

    localparam int HSPN_DEF = 240000;
    localparam int DBN_DEF  = 16;

    typedef enum logic [1:0] {
        ST_CLR   = 2'd0,
        ST_RUN   = 2'd1,
        ST_SPLIT = 2'd2,
        ST_STOP  = 2'd3
    } sw_state_e;

    // The time base advances in both running states; SPLIT only freezes the display.
    function automatic logic is_running(sw_state_e st);
        return (st == ST_RUN) || (st == ST_SPLIT);
    endfunction

    function automatic int cnt_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Button inputs and controller outputs of the stopwatch control block.
interface stopwatch_if;

    logic b_run;
    logic b_clr;
    logic cnt_inc;
    logic cnt_clr;
    logic dsp_upd;
    logic s_run;
    logic s_hld;

    modport master (
        output b_run, b_clr,
        input  cnt_inc, cnt_clr, dsp_upd, s_run, s_hld
    );

    modport slave (
        input  b_run, b_clr,
        output cnt_inc, cnt_clr, dsp_upd, s_run, s_hld
    );

endinterface

// File: rtl/stopwatch_debounce.sv
// One button channel: 2-flop synchronizer, stability-count debouncer and
// rising-edge press detector.
module stopwatch_debounce
    import stopwatch_pkg::*;
#(
    parameter int DBN = DBN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic lvl,
    output logic prs
);

    localparam int CW = cnt_width(DBN);
    localparam logic [CW-1:0] CNT_LAST = CW'(DBN - 1);

    logic [1:0]    sync_q;
    logic [1:0]    vld_q;
    logic          lvl_q;
    logic          lvl_dly_q;
    logic          armed_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q    <= 2'b00;
            vld_q     <= 2'b00;
            lvl_q     <= 1'b0;
            lvl_dly_q <= 1'b0;
            armed_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync_q    <= {sync_q[0], btn};
            vld_q     <= {vld_q[0], 1'b1};
            lvl_dly_q <= lvl_q;
            // A button held through reset must be seen released before it can press.
            if (vld_q[1] && !sync_q[1]) begin
                armed_q <= 1'b1;
            end
            if (sync_q[1] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                lvl_q <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign lvl = lvl_q;
    assign prs = lvl_q & ~lvl_dly_q & armed_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced run/clear buttons drive a CLR/RUN/SPLIT/STOP
// state machine and a hundredths prescaler feeding the BCD time counter.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int HSPN = HSPN_DEF,
    parameter int DBN  = DBN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic b_run,
    input  logic b_clr,
    output logic cnt_inc,
    output logic cnt_clr,
    output logic dsp_upd,
    output logic s_run,
    output logic s_hld
);

    localparam int PW = cnt_width(HSPN);
    localparam logic [PW-1:0] PRE_LAST = PW'(HSPN - 1);

    // Index 0 is the run button, index 1 the clear/split button.
    logic [1:0] btn_raw;
    logic [1:0] btn_lvl_unused;
    logic [1:0] btn_prs;

    assign btn_raw = {b_clr, b_run};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            stopwatch_debounce #(
                .DBN (DBN)
            ) u_debounce (
                .clk (clk),
                .rst (rst),
                .btn (btn_raw[gi]),
                .lvl (btn_lvl_unused[gi]),
                .prs (btn_prs[gi])
            );
        end
    endgenerate

    logic run_ev;
    logic clr_ev;

    assign run_ev = btn_prs[0];
    assign clr_ev = btn_prs[1] & ~btn_prs[0];

    sw_state_e     state_q;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          cnt_clr_q;

    always_comb begin
        pre_d = pre_q;
        if (state_q == ST_CLR) begin
            pre_d = '0;
        end else if (is_running(state_q)) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_CLR;
            pre_q     <= '0;
            cnt_clr_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            cnt_clr_q <= 1'b0;
            case (state_q)
                ST_CLR: begin
                    if (run_ev) begin
                        state_q <= ST_RUN;
                    end else if (clr_ev) begin
                        cnt_clr_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_ev) begin
                        state_q <= ST_STOP;
                    end else if (clr_ev) begin
                        state_q <= ST_SPLIT;
                    end
                end
                ST_SPLIT: begin
                    if (run_ev) begin
                        state_q <= ST_STOP;
                    end else if (clr_ev) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_STOP: begin
                    if (run_ev) begin
                        state_q <= ST_RUN;
                    end else if (clr_ev) begin
                        state_q   <= ST_CLR;
                        cnt_clr_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_CLR;
                end
            endcase
        end
    end

    assign s_run   = is_running(state_q);
    assign s_hld   = (state_q == ST_SPLIT);
    assign dsp_upd = (state_q != ST_SPLIT);
    assign cnt_inc = is_running(state_q) && (pre_q == PRE_LAST);
    assign cnt_clr = cnt_clr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button activity,
// compared every cycle against a behavioural model of the stopwatch rules.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int HSPN = 10;
    localparam int DBN  = 4;

    logic clk = 1'b0;
    logic rst;

    stopwatch_if sw ();

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .HSPN (HSPN),
        .DBN  (DBN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .b_run   (sw.b_run),
        .b_clr   (sw.b_clr),
        .cnt_inc (sw.cnt_inc),
        .cnt_clr (sw.cnt_clr),
        .dsp_upd (sw.dsp_upd),
        .s_run   (sw.s_run),
        .s_hld   (sw.s_hld)
    );

    // Model state: mode, completed running cycles since clear, pending clear pulse,
    // and per button the sampled pipeline, accepted level, streak and release flag.
    sw_state_e m_st;
    int        m_runcyc;
    bit        m_clrp;
    int        m_edges;
    bit        m_pend   [2];
    bit        m_lvl    [2];
    bit        m_s1     [2];
    bit        m_s2     [2];
    bit        m_armed  [2];
    int        m_streak [2];

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    function automatic logic exp_srun();
        return (m_st == ST_RUN) || (m_st == ST_SPLIT);
    endfunction

    function automatic logic exp_inc();
        return exp_srun() && (((m_runcyc + 1) % HSPN) == 0);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        check("s_run",   sw.s_run,   exp_srun());
        check("s_hld",   sw.s_hld,   m_st == ST_SPLIT);
        check("dsp_upd", sw.dsp_upd, m_st != ST_SPLIT);
        check("cnt_inc", sw.cnt_inc, exp_inc());
        check("cnt_clr", sw.cnt_clr, m_clrp);
    endtask

    task automatic model_edge();
        bit raw [2];
        bit ev_r;
        bit ev_c;
        bit running;
        raw[0] = sw.b_run;
        raw[1] = sw.b_clr;
        if (!rst) begin
            m_st     = ST_CLR;
            m_runcyc = 0;
            m_clrp   = 1'b0;
            m_edges  = 0;
            for (int i = 0; i < 2; i++) begin
                m_pend[i]   = 1'b0;
                m_lvl[i]    = 1'b0;
                m_s1[i]     = 1'b0;
                m_s2[i]     = 1'b0;
                m_armed[i]  = 1'b0;
                m_streak[i] = 0;
            end
            return;
        end
        ev_r    = m_pend[0];
        ev_c    = m_pend[1] && !ev_r;
        running = exp_srun();
        m_clrp  = 1'b0;
        if (m_st == ST_CLR) m_runcyc = 0;
        else if (running)   m_runcyc++;
        // Run toggles between going and stopped; clear splits/unsplits or zeroes.
        if (ev_r) begin
            m_st = running ? ST_STOP : ST_RUN;
        end else if (ev_c) begin
            if (running) begin
                m_st = (m_st == ST_RUN) ? ST_SPLIT : ST_RUN;
            end else begin
                m_st   = ST_CLR;
                m_clrp = 1'b1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 1'b0;
            if (m_edges >= 2 && !m_s2[i]) m_armed[i] = 1'b1;
            if (m_s2[i] != m_lvl[i]) begin
                m_streak[i]++;
                if (m_streak[i] == DBN) begin
                    m_lvl[i]    = m_s2[i];
                    m_streak[i] = 0;
                    m_pend[i]   = m_lvl[i] && m_armed[i];
                end
            end else begin
                m_streak[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
        m_edges++;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            model_edge();
            @(posedge clk);
            @(negedge clk);
            cyc++;
            compare_all();
        end
    endtask

    initial begin
        rst      = 1'b0;
        sw.b_run = 1'b0;
        sw.b_clr = 1'b0;
        @(negedge clk);

        // Reset outputs
        step(2);
        check("rst_s_run", sw.s_run, 1'b0);
        check("rst_s_hld", sw.s_hld, 1'b0);
        check("rst_dsp_upd", sw.dsp_upd, 1'b1);
        check("rst_cnt_inc", sw.cnt_inc, 1'b0);
        check("rst_cnt_clr", sw.cnt_clr, 1'b0);
        rst = 1'b1;
        step(4);

        // Short glitch is ignored
        sw.b_run = 1'b1; step(3);
        sw.b_run = 1'b0; step(10);
        check("glitch_s_run", sw.s_run, 1'b0);

        // Clean press: RUN exactly DBN+3 edges after first sampling
        sw.b_run = 1'b1; step(6);
        check("lat_pre_dut", sw.s_run, 1'b0);
        check("lat_pre_model", exp_srun(), 1'b0);
        step(1);
        check("lat_dut", sw.s_run, 1'b1);
        check("lat_model", exp_srun(), 1'b1);
        step(3);
        sw.b_run = 1'b0; step(5);
        check("inc9_dut", sw.cnt_inc, 1'b0);
        step(1);
        check("inc10_dut", sw.cnt_inc, 1'b1);
        check("inc10_model", exp_inc(), 1'b1);
        step(20);

        // Split and unsplit
        sw.b_clr = 1'b1; step(DBN + 2);
        sw.b_clr = 1'b0; step(6);
        check("split_s_hld", sw.s_hld, 1'b1);
        check("split_dsp_upd", sw.dsp_upd, 1'b0);
        step(20);
        sw.b_clr = 1'b1; step(DBN + 2);
        sw.b_clr = 1'b0; step(6);
        check("unsplit_s_hld", sw.s_hld, 1'b0);
        check("unsplit_dsp_upd", sw.dsp_upd, 1'b1);

        // Stop, then clear: single cnt_clr pulse
        sw.b_run = 1'b1; step(DBN + 2);
        sw.b_run = 1'b0; step(8);
        check("stop_s_run", sw.s_run, 1'b0);
        sw.b_clr = 1'b1; step(DBN + 3);
        check("clr_pulse", sw.cnt_clr, 1'b1);
        step(1);
        check("clr_pulse_end", sw.cnt_clr, 1'b0);
        sw.b_clr = 1'b0; step(8);

        // 25 running cycles, stop, resume: fractional hundredth kept
        sw.b_run = 1'b1; step(7);
        step(3);
        sw.b_run = 1'b0; step(15);
        sw.b_run = 1'b1; step(6);
        step(1);
        check("stop25_s_run", sw.s_run, 1'b0);
        sw.b_run = 1'b0; step(10);
        sw.b_run = 1'b1; step(7);
        check("resume_s_run", sw.s_run, 1'b1);
        check("resume26_inc", sw.cnt_inc, 1'b0);
        step(3);
        check("resume29_inc", sw.cnt_inc, 1'b0);
        sw.b_run = 1'b0; step(1);
        check("resume30_inc", sw.cnt_inc, 1'b1);
        step(12);

        // Simultaneous presses in RUN: run wins, never SPLIT
        sw.b_run = 1'b1; sw.b_clr = 1'b1; step(DBN + 3);
        check("simul_s_run", sw.s_run, 1'b0);
        check("simul_s_hld", sw.s_hld, 1'b0);
        sw.b_run = 1'b0; sw.b_clr = 1'b0; step(10);

        // Reset mid-RUN
        sw.b_run = 1'b1; step(DBN + 2);
        sw.b_run = 1'b0; step(12);
        rst = 1'b0; step(2);
        check("midrst_s_run", sw.s_run, 1'b0);
        check("midrst_dsp_upd", sw.dsp_upd, 1'b1);
        rst = 1'b1; step(5);

        // Button held through reset is ignored until re-pressed
        sw.b_run = 1'b1;
        rst = 1'b0; step(2);
        rst = 1'b1; step(20);
        check("held_s_run", sw.s_run, 1'b0);
        sw.b_run = 1'b0; step(10);

        // Random button activity with occasional resets
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                step($urandom_range(1, 3));
                rst = 1'b1;
            end
            sw.b_run = ($urandom_range(0, 2) == 0);
            sw.b_clr = ($urandom_range(0, 2) == 0);
            step($urandom_range(1, 12));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule
